// File: rtl/madd_pkg.sv
// Shared definitions for the DMADD command loader: opcodes, header field layout, FSM states.
package madd_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_WAIT = 2'b11;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int ARG_MSB = 5;
  localparam int ARG_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_DATA,
    ST_LOAD_LO,
    ST_LOAD_HI,
    ST_RUN,
    ST_WAIT
  } state_e;

  function automatic logic [1:0] hdr_op(input logic [7:0] b);
    return b[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [5:0] hdr_arg(input logic [7:0] b);
    return b[ARG_MSB:ARG_LSB];
  endfunction

endpackage

// File: rtl/madd_cmd_fifo.sv
// Command-byte FIFO; registered pointers, so a push at edge N is poppable from edge N+1.
// Pointers carry an extra wrap bit to tell full from empty; push ignored when full, pop when empty.
module madd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only read behind a valid pointer pair.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/madd_cmd_loader.sv
// Expands queued command bytes into DMADD load/run strobes; outputs are a registered copy of FSM state.
// Input stalls only when the command FIFO is full.
module madd_cmd_loader
  import madd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       madd_load,
  output logic       madd_run,
  output logic [1:0] madd_insn,
  output logic [3:0] madd_index,
  output logic [3:0] madd_data,
  output logic       busy
);

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_rd;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic [1:0] hdr_insn_q, hdr_insn_d;

  logic       load_q, load_d;
  logic       run_q, run_d;
  logic [1:0] insn_q, insn_d;
  logic [3:0] index_q, index_d;
  logic [3:0] data_q, data_d;
  logic       busy_q, busy_d;

  assign in_ready = !fifo_full;

  madd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    hdr_insn_d = hdr_insn_q;
    fifo_pop   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          unique case (hdr_op(fifo_rd))
            OP_LOAD: begin
              idx_d   = fifo_rd[3:0];
              state_d = ST_GET_DATA;
            end
            OP_RUN: begin
              hdr_insn_d = fifo_rd[1:0];
              cnt_d      = {2'b00, fifo_rd[5:2]};
              state_d    = ST_RUN;
            end
            OP_WAIT: begin
              cnt_d   = hdr_arg(fifo_rd);
              state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_GET_DATA: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          byte_d   = fifo_rd;
          state_d  = ST_LOAD_LO;
        end
      end
      ST_LOAD_LO: state_d = ST_LOAD_HI;
      ST_LOAD_HI: state_d = ST_IDLE;
      // The counter holds remaining cycles minus one, so zero marks the last cycle.
      ST_RUN, ST_WAIT: begin
        if (cnt_q == 6'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 6'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_d  = 1'b0;
    run_d   = 1'b0;
    insn_d  = insn_q;
    index_d = index_q;
    data_d  = data_q;
    busy_d  = (state_q != ST_IDLE) || !fifo_empty;

    unique case (state_q)
      ST_LOAD_LO: begin
        load_d  = 1'b1;
        index_d = idx_q;
        data_d  = byte_q[3:0];
      end
      ST_LOAD_HI: begin
        load_d  = 1'b1;
        index_d = idx_q + 4'd1;
        data_d  = byte_q[7:4];
      end
      ST_RUN: begin
        run_d  = 1'b1;
        insn_d = hdr_insn_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      hdr_insn_q <= '0;
      load_q     <= 1'b0;
      run_q      <= 1'b0;
      insn_q     <= '0;
      index_q    <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      hdr_insn_q <= hdr_insn_d;
      load_q     <= load_d;
      run_q      <= run_d;
      insn_q     <= insn_d;
      index_q    <= index_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
    end
  end

  assign madd_load  = load_q;
  assign madd_run   = run_q;
  assign madd_insn  = insn_q;
  assign madd_index = index_q;
  assign madd_data  = data_q;
  assign busy       = busy_q;

endmodule

// File: doc/madd_cmd_loader.md
# madd_cmd_loader

Command sequencer directly upstream of the DMADD multiply-add core. Accepts a byte stream of commands over a valid/ready handshake, buffers them in a small FIFO, and expands each command into the cycle-exact `load`/`run`/`insn`/`index`/`data` strobes DMADD consumes. This lets a slow host or pin interface queue work without meeting DMADD's per-cycle control timing.

## Interface
- `FIFO_DEPTH`, default 4: command-byte FIFO entries; power of two, at least 2.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  command or data byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  FIFO not full; combinational `!full`.
- `madd_load`  out  1  to DMADD `load`.
- `madd_run`  out  1  to DMADD `run`.
- `madd_insn`  out  2  to DMADD `insn`.
- `madd_index`  out  4  to DMADD `index`.
- `madd_data`  out  4  to DMADD `data`.
- `busy`  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- The FIFO pushes a byte when `in_valid && in_ready`. Push and pop may occur in the same cycle. A full FIFO never accepts a byte. The FIFO never pops when empty.
- Header byte: `op = [7:6]`, `arg = [5:0]`.
  - `op` 00 NOP: consumed; no strobes.
  - `op` 01 LOAD: `index = arg[3:0]`; `arg[5:4]` ignored. The next byte is data. Cycle 1: `load=1`, `index`, `data = byte[3:0]`. Cycle 2: `load=1`, `index+1` (mod 16, 15 wraps to 0), `data = byte[7:4]`.
  - `op` 10 RUN: `insn = arg[1:0]`, `count = arg[5:2]+1` (1..16). `run=1` for exactly `count` consecutive cycles, with `insn` held.
  - `op` 11 WAIT: idle for `arg+1` cycles (1..64) with strobes low.
- FSM states: IDLE, GET_DATA, LOAD_LO, LOAD_HI, RUN, WAIT.
  - IDLE → on non-empty FIFO, pop the header, then go to GET_DATA (LOAD), RUN, WAIT, or stay in IDLE (NOP).
  - GET_DATA → wait in place while the FIFO is empty; when a byte is available, pop it and go to LOAD_LO.
  - LOAD_LO → LOAD_HI → IDLE.
  - RUN → decrement the counter; go to IDLE after the last cycle.
  - WAIT → decrement the counter; go to IDLE at zero.
- `madd_load` is high only in LOAD_LO and LOAD_HI. `madd_run` is high only in RUN. Both are never high together.
- Every command passes through IDLE, so back-to-back commands have at least one cycle with `load = run = 0` between their strobes.
- `madd_insn`, `madd_index`, and `madd_data` hold their last values when the strobes are low.

## Timing
- All DMADD-facing outputs and `busy` are registered. On reset they all go to 0 immediately (asynchronous) and the FIFO empties. `in_ready` is 1 while and after reset.
- Reset mid-command aborts the command. Partially consumed commands are discarded. A pending LOAD data byte that was not yet pushed is treated as a new header afterwards.
- A byte pushed at edge N is visible to the FSM at edge N+1.
- LOAD, header popped at edge t, data already queued: data popped at t+1; `load` is high during cycles t+2 and t+3 and low at t+4.
- RUN, header popped at edge t: `run` is high from t+1 through t+count.
- The FIFO stalls input only when full. Throughput is limited by the FSM, not by the handshake.

## Structure
- Shared package `madd_pkg` holds:
  - opcode localparams `OP_NOP`, `OP_LOAD`, `OP_RUN`, `OP_WAIT`;
  - the FSM state enum;
  - field positions for `op` and `arg`.
- Sub-module `madd_cmd_fifo`: synchronous FIFO, parameterised depth and width 8. It has push/pop/full/empty, an async active-high `rst`, and pointer wrap with an extra MSB for the full/empty distinction.
- The top contains the FSM, the 6-bit down-counter, and the output registers.

## Test plan
- Reset with the FIFO holding 3 bytes and the FSM in RUN → all outputs 0 and `busy=0` on the same cycle; `in_ready=1`; the next header decodes cleanly.
- LOAD: send 0x4F then 0xA5 → `load` high for 2 cycles with (`index` 0xF, `data` 0x5) then (`index` 0x0, `data` 0xA).
- RUN: send 0xBE (`insn=2`, `count=16`) → `run` high for exactly 16 cycles with `insn=2`, then low.
- Push 6 bytes without a gap against `FIFO_DEPTH=4` while the FSM is in WAIT 0xFF → `in_ready` drops after 4 accepted bytes and recovers on the first pop; no byte is lost or duplicated.
- LOAD header followed by data arriving 5 cycles later → FSM holds in GET_DATA with `load=0`, then strobes correctly.
- Back-to-back RUN 0x80 and RUN 0x81 → `run` high 1 cycle with `insn 0`, low 1 cycle, then high 1 cycle with `insn 1`.
